// File: rtl/vp_bbox_overlay.sv
// Bounding-box overlay for the binary-mask video stream: accumulates the box of
// foreground pixels per frame, latches it on v_sync rise and outlines it on the next frame.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// WAIT_VS | after reset: pass pixels through, wait for first v_sync rise
// ACTIVE  | accumulate foreground box, latch and restart on every v_sync rise
`timescale 1ns/1ps
module vp_bbox_overlay #(
    parameter int          COORD_W   = 11,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [23:0]        pixel_in,
    input  logic               overlay_en,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [23:0]        pixel_out,
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
    output logic               bbox_valid
);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    localparam logic [COORD_W-1:0] C_MAX = '1;
    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

    state_t state, state_nxt;

    logic               de_d, vs_d;
    logic [COORD_W-1:0] x, y;
    logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic               acc_seen;

    logic               vs_rise, line_end, fg;
    logic               acc_clr, acc_upd, latch;
    logic [COORD_W-1:0] m_xmin, m_xmax, m_ymin, m_ymax;
    logic               m_seen;
    logic               on_vert, on_horz, draw;

    assign vs_rise  = v_sync_in & ~vs_d;
    assign line_end = de_d & ~de_in;
    assign fg       = de_in & pixel_in[7];

    // Accumulator values including the current pixel, so a foreground pixel on
    // the v_sync rise cycle still lands in the closing frame's box.
    assign m_xmin = (fg && x < acc_xmin) ? x : acc_xmin;
    assign m_xmax = (fg && x > acc_xmax) ? x : acc_xmax;
    assign m_ymin = (fg && y < acc_ymin) ? y : acc_ymin;
    assign m_ymax = (fg && y > acc_ymax) ? y : acc_ymax;
    assign m_seen = acc_seen | fg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_upd   = 1'b0;
        latch     = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_nxt = ACTIVE;
                    acc_clr   = 1'b1;
                end
            end
            ACTIVE: begin
                acc_upd = fg;
                if (vs_rise) begin
                    latch   = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_d <= 1'b0;
            vs_d <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            de_d <= de_in;
            vs_d <= v_sync_in;
            if (vs_rise) begin
                x <= '0;
                y <= '0;
            end else if (line_end) begin
                x <= '0;
                y <= (y == C_MAX) ? y : y + C_ONE;
            end else if (de_in) begin
                x <= (x == C_MAX) ? x : x + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_xmin <= C_MAX;
            acc_xmax <= '0;
            acc_ymin <= C_MAX;
            acc_ymax <= '0;
            acc_seen <= 1'b0;
        end else if (acc_clr) begin
            acc_xmin <= C_MAX;
            acc_xmax <= '0;
            acc_ymin <= C_MAX;
            acc_ymax <= '0;
            acc_seen <= 1'b0;
        end else if (acc_upd) begin
            acc_xmin <= m_xmin;
            acc_xmax <= m_xmax;
            acc_ymin <= m_ymin;
            acc_ymax <= m_ymax;
            acc_seen <= m_seen;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            bbox_valid <= 1'b0;
        end else if (latch) begin
            bbox_xmin  <= m_xmin;
            bbox_xmax  <= m_xmax;
            bbox_ymin  <= m_ymin;
            bbox_ymax  <= m_ymax;
            bbox_valid <= m_seen;
        end
    end

    assign on_vert = (x == bbox_xmin || x == bbox_xmax) && y >= bbox_ymin && y <= bbox_ymax;
    assign on_horz = (y == bbox_ymin || y == bbox_ymax) && x >= bbox_xmin && x <= bbox_xmax;
    assign draw    = overlay_en & bbox_valid & de_in & (on_vert | on_horz);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            de_out     <= de_in;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            pixel_out  <= draw ? BOX_COLOR : pixel_in;
        end
    end

endmodule

// File: tb/tb_vp_bbox_overlay.sv
// Scoreboard bench for vp_bbox_overlay: 64x64 frames with directed foreground
// patterns; stream outputs are checked by a queue monitor, boxes at frame boundaries.
`timescale 1ns/1ps
module tb_vp_bbox_overlay;
    localparam int          CW    = 11;
    localparam logic [23:0] BOX   = 24'hFF0000;
    localparam logic [23:0] BLANK = 24'h00FF80;
    localparam logic [23:0] FG    = 24'hFFFFFF;
    localparam int          EMAX  = 2047;

    logic clk = 1'b0;
    logic rst_n, de_in, h_sync_in, v_sync_in, overlay_en;
    logic [23:0] pixel_in;
    logic de_out, h_sync_out, v_sync_out, bbox_valid;
    logic [23:0] pixel_out;
    logic [CW-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

    always #5 clk = ~clk;

    vp_bbox_overlay #(.COORD_W(CW), .BOX_COLOR(BOX)) dut (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .pixel_in(pixel_in), .overlay_en(overlay_en),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .pixel_out(pixel_out), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .bbox_valid(bbox_valid)
    );

    typedef struct {
        int          c;
        logic [26:0] e;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   dut_ovl = 0;

    // frame description
    bit fg_on;   int fx0, fx1, fy0, fy1;
    bit e_on;    int ex0, ex1, ey0, ey1;
    bit chk_on;  int cx0, cx1, cy0, cy1; bit cv;
    bit ovl_base; int on_row, on_col;
    bit inject;  int rst_line;
    int exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        exp_t        t;
        logic [26:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].c < cyc) begin
                t   = sb.pop_front();
                got = {de_out, h_sync_out, v_sync_out, pixel_out};
                tests++;
                if (got !== t.e) begin
                    fails++;
                    $display("FAIL stream in_cyc=%0d got=%h want=%h", t.c, got, t.e);
                end
                if (got[26] && got[23:0] == BOX) dut_ovl++;
            end
        end
    end

    task automatic drive(input logic d, input logic h, input logic v, input logic [23:0] p,
                         input logic o, input logic [23:0] ep, input logic r);
        exp_t t;
        @(posedge clk);
        #1;
        rst_n      = r;
        de_in      = d;
        h_sync_in  = h;
        v_sync_in  = v;
        pixel_in   = p;
        overlay_en = o;
        t.c = cyc;
        t.e = r ? {d, h, v, ep} : 27'd0;
        sb.push_back(t);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic check_box(input int x0, input int x1, input int y0, input int y1, input int v);
        chk("bbox_xmin", int'(bbox_xmin), x0);
        chk("bbox_xmax", int'(bbox_xmax), x1);
        chk("bbox_ymin", int'(bbox_ymin), y0);
        chk("bbox_ymax", int'(bbox_ymax), y1);
        chk("bbox_valid", int'(bbox_valid), v);
    endtask

    task automatic defaults();
        fg_on = 0; e_on = 0; chk_on = 0; cv = 0;
        ovl_base = 1; on_row = 1000; on_col = 0;
        inject = 0; rst_line = -1; exp_cnt = 0;
    endtask

    task automatic set_fg(input int x0, input int x1, input int y0, input int y1);
        fg_on = 1; fx0 = x0; fx1 = x1; fy0 = y0; fy1 = y1;
    endtask

    task automatic set_draw(input int x0, input int x1, input int y0, input int y1);
        e_on = 1; ex0 = x0; ex1 = x1; ey0 = y0; ey1 = y1;
    endtask

    task automatic set_latch(input int x0, input int x1, input int y0, input int y1, input bit v);
        chk_on = 1; cx0 = x0; cx1 = x1; cy0 = y0; cy1 = y1; cv = v;
    endtask

    task automatic run_frame();
        int          base;
        logic        ov, fg, draw, e_live;
        logic [23:0] p, ep;
        base   = dut_ovl;
        ov     = ovl_base;
        e_live = e_on;
        drive(inject, 0, 1, inject ? FG : BLANK, ov, inject ? FG : BLANK, 1);
        drive(0, 0, 1, BLANK, ov, BLANK, 1);
        if (chk_on) check_box(cx0, cx1, cy0, cy1, int'(cv));
        drive(0, 0, 0, BLANK, ov, BLANK, 1);
        for (int row = 0; row < 64; row++) begin
            if (row == rst_line) begin
                drive(0, 0, 0, BLANK, ov, BLANK, 0);
                drive(0, 0, 0, BLANK, ov, BLANK, 0);
                check_box(0, 0, 0, 0, 0);
                e_live = 0;
            end
            drive(0, 1, 0, BLANK, ov, BLANK, 1);
            drive(0, 0, 0, BLANK, ov, BLANK, 1);
            for (int col = 0; col < 64; col++) begin
                ov   = ovl_base || row > on_row || (row == on_row && col >= on_col);
                fg   = fg_on && col >= fx0 && col <= fx1 && row >= fy0 && row <= fy1;
                p    = fg ? FG : {8'(row), 8'(col), 1'b0, 7'(row + col)};
                draw = ov && e_live &&
                       (((col == ex0 || col == ex1) && row >= ey0 && row <= ey1) ||
                        ((row == ey0 || row == ey1) && col >= ex0 && col <= ex1));
                ep   = draw ? BOX : p;
                drive(1, 0, 0, p, ov, ep, 1);
            end
            drive(0, 0, 0, BLANK, ov, BLANK, 1);
        end
        @(negedge clk);
        #1;
        chk("overlay_count", dut_ovl - base, exp_cnt);
    endtask

    initial begin : stim
        rst_n = 0; de_in = 0; h_sync_in = 0; v_sync_in = 0; overlay_en = 0; pixel_in = '0;
        for (int i = 0; i < 4; i++) drive(0, 0, 0, BLANK, 0, BLANK, 0);
        check_box(0, 0, 0, 0, 0);

        // F0-F2: background only, first v_sync just arms the FSM
        defaults(); run_frame();
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); run_frame();
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); run_frame();
        // F3: block, F4: its 28-pixel outline plus a lone pixel at (63,63)
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); set_fg(10, 20, 5, 9); run_frame();
        defaults(); set_latch(10, 20, 5, 9, 1); set_draw(10, 20, 5, 9); set_fg(63, 63, 63, 63);
        exp_cnt = 28; run_frame();
        defaults(); set_latch(63, 63, 63, 63, 1); set_draw(63, 63, 63, 63); exp_cnt = 1; run_frame();
        // F6 empty; F7 opens with a foreground pixel on the v_sync rise cycle at (0,64)
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); run_frame();
        defaults(); inject = 1; set_latch(0, 0, 64, 64, 1); ovl_base = 0; run_frame();
        // F8 proves the new accumulators started empty; reset lands inside F9
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); set_fg(10, 20, 5, 9); run_frame();
        defaults(); set_latch(10, 20, 5, 9, 1); set_draw(10, 20, 5, 9); rst_line = 30;
        exp_cnt = 28; run_frame();
        defaults(); set_latch(0, 0, 0, 0, 0); set_fg(10, 20, 5, 9); run_frame();
        defaults(); set_latch(10, 20, 5, 9, 1); set_draw(10, 20, 5, 9); set_fg(30, 40, 20, 25);
        exp_cnt = 28; run_frame();
        // F12: overlay_en switched on mid-line at (35,20)
        defaults(); set_latch(30, 40, 20, 25, 1); set_draw(30, 40, 20, 25);
        ovl_base = 0; on_row = 20; on_col = 35; set_fg(50, 52, 60, 61); exp_cnt = 25; run_frame();
        defaults(); set_latch(50, 52, 60, 61, 1); set_draw(50, 52, 60, 61); ovl_base = 0; run_frame();
        defaults(); set_latch(EMAX, 0, EMAX, 0, 0); run_frame();

        for (int i = 0; i < 3; i++) drive(0, 0, 0, BLANK, 0, BLANK, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vp_bbox_overlay.md
Name: vp_bbox_overlay

Overview:
- Video stage placed directly downstream of vp; consumes its binary-mask stream (each pixel 0x000000 or 0xFFFFFF) before the output sink.
- Tracks pixel coordinates from de/v_sync, accumulates the bounding box of foreground pixels over each frame and latches it at the frame boundary.
- Draws that box as a 1-pixel rectangle over the following frame.
- Exports the box coordinates for later stages.

Parameters:
- COORD_W, 11, width of x/y counters and box coordinates.
- BOX_COLOR, 24'hFF0000, RGB value drawn on the rectangle outline.

Ports:
- clk  in  1  pixel clock, shared with the upstream vp stage
- rst_n  in  1  synchronous active-low reset
- de_in  in  1  data enable from vp
- h_sync_in  in  1  horizontal sync from vp
- v_sync_in  in  1  vertical sync from vp, active high
- pixel_in  in  24  {R,G,B} mask pixel; foreground when pixel_in[7]=1
- overlay_en  in  1  1: draw box; 0: pass pixels through, still accumulate
- de_out  out  1  delayed de_in
- h_sync_out  out  1  delayed h_sync_in
- v_sync_out  out  1  delayed v_sync_in
- pixel_out  out  24  pixel_in, or BOX_COLOR on the outline
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  COORD_W each  last latched box
- bbox_valid  out  1  latched box holds at least one foreground pixel

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n.
- Reset values: all outputs 0; FSM = WAIT_VS; x=y=0; accumulators empty (min = all-ones, max = 0, seen = 0).
- Latency: exactly 1 clk for de, h_sync, v_sync and pixel. Output sync/de alignment is identical to input.
- Registered copies: de_d and vs_d of de_in and v_sync_in.
- Edge detection:
  - vs_rise = v_sync_in & ~vs_d.
  - line_end = de_d & ~de_in.
- Coordinates:
  - x = count of de_in=1 pixels earlier in the current line.
  - On de_in=1: x <= x+1, saturating at 2^COORD_W-1.
  - On line_end: x <= 0 and y <= y+1, saturating.
  - On vs_rise: x <= 0, y <= 0.
- FSM WAIT_VS:
  - Pass-through; no accumulation; bbox_valid unchanged.
  - On vs_rise go to ACTIVE and clear the accumulators. No latch happens on this edge.
- FSM ACTIVE:
  - Every cycle with de_in=1 and pixel_in[7]=1 updates the accumulators: xmin = min(xmin,x), xmax = max(xmax,x), same for y, and sets seen.
  - On vs_rise: bbox_* <= accumulator values including the current-cycle pixel, if one is present; bbox_valid <= seen (or current foreground).
  - After the latch, clear the accumulators. Stay in ACTIVE.
- Simultaneous events:
  - A foreground pixel coincident with vs_rise belongs to the closing frame.
  - line_end coincident with vs_rise: the vs_rise coordinate reset wins.
- Overlay: pixel_out = BOX_COLOR when all of the following hold, else pixel_out = pixel_in (delayed 1 clk):
  - overlay_en = 1, bbox_valid = 1, de_in = 1;
  - and either (x==bbox_xmin or x==bbox_xmax) with bbox_ymin ≤ y ≤ bbox_ymax,
  - or (y==bbox_ymin or y==bbox_ymax) with bbox_xmin ≤ x ≤ bbox_xmax.
- pixel_out while de_in=0: pass-through of pixel_in.
- Degenerate boxes: a single foreground pixel gives xmin=xmax, ymin=ymax and draws exactly one pixel.
- Reset mid-frame: everything returns to reset values. No box is drawn until one full frame has been accumulated after the next vs_rise.
- overlay_en toggling takes effect on the next pixel; it does not affect accumulation.

Test Plan:
- 64x64 frames, all background, 3 frames -> bbox_valid=0 throughout; pixel_out equals pixel_in delayed by exactly 1 clk; de/hs/vs delayed 1 clk.
- Frame 2 has foreground block x=10..20, y=5..9 -> at frame-3 vs_rise: bbox = (10,20,5,9), valid=1.
  - Frame 3 has exactly 2*11+2*3 = 28 pixels = 0xFF0000 at the outline coordinates; all others pass through.
- Single foreground pixel at (63,63), the last pixel of the frame -> latched box (63,63,63,63); exactly one overlay pixel in the next frame.
- Foreground pixel coincident with the vs_rise cycle (injected de with v_sync rising) -> that pixel is included in the latched box of the closing frame; new-frame accumulators start empty.
- rst_n low for 2 clk in mid-frame, after a valid box -> all outputs 0 during reset. The first following frame (after vs_rise) shows no overlay. The box appears only on the frame after the next one.
- overlay_en=0 with box present -> pixel_out == delayed pixel_in; bbox_* still update at each frame boundary. Set overlay_en=1 mid-line -> overlay starts on the next eligible pixel.
